// File: rtl/imem_fetch_resp.sv
// Instruction-memory fetch responder: word-addressed store, one registered read
// stage (S1) and an output FIFO, with valid/ready on both sides and a flush.
module imem_fetch_resp #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic                     flush,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_instr,
  output logic [ADDRESS_WIDTH-1:0] rsp_addr,
  output logic                     rsp_err,
  input  logic                     ld_en,
  input  logic [MEM_ADDR_BITS-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]    ld_data
);

  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int MEM_DEPTH = 1 << MEM_ADDR_BITS;

  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    instr;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     err;
  } entry_t;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  r_s1_valid;
  entry_t                r_s1;

  entry_t                r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  entry_t                r_last;

  logic                     w_clear;
  logic [MEM_ADDR_BITS-1:0] w_word_idx;
  logic                     w_req_err;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_pop;
  logic [CNT_W-1:0]         w_occupancy;
  entry_t                   w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_clear     = rst || flush;
  assign w_word_idx  = req_addr[MEM_ADDR_BITS+1:2];
  assign w_req_err   = (req_addr[1:0] != 2'b00) ||
                       (req_addr[ADDRESS_WIDTH-1:MEM_ADDR_BITS+2] != '0);

  // Admission counts the S1 slot too, so S1 always has a FIFO slot to land in.
  assign w_occupancy = r_count + CNT_W'(r_s1_valid);
  assign req_ready   = !w_clear && (w_occupancy < DEPTH_CNT);
  assign w_accept    = req_valid && req_ready;

  assign w_push      = r_s1_valid && !w_clear;
  assign rsp_valid   = (r_count != '0) && !w_clear;
  assign w_pop       = rsp_valid && rsp_ready;

  // Outputs hold the last popped entry while the FIFO is empty.
  assign w_head      = (r_count != '0) ? r_fifo[r_rd_ptr] : r_last;
  assign rsp_instr   = w_head.instr;
  assign rsp_addr    = w_head.addr;
  assign rsp_err     = w_head.err;

  // NOTE: program store is deliberately not reset; it keeps its contents across rst.
  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (w_clear) r_s1_valid <= 1'b0;
    else         r_s1_valid <= w_accept;
  end

  // NOTE: non-blocking assignment makes a same-edge load invisible here, giving read-first.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1.instr <= w_req_err ? NOP_INSTR : r_mem[w_word_idx];
      r_s1.addr  <= req_addr;
      r_s1.err   <= w_req_err;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= r_s1;
  end

  always_ff @(posedge clk) begin
    if (rst)        r_last <= '0;
    else if (w_pop) r_last <= r_fifo[r_rd_ptr];
  end

endmodule
